// File: rtl/instr_fetch_if.sv
// Instruction stream bus between the fetch unit (slave side here) and the
// surrounding control/decoder logic (master side).
interface instr_fetch_if #(
    parameter int PROG_DEPTH = 16
);
    localparam int PC_W = $clog2(PROG_DEPTH);

    logic            step;
    logic            start;
    logic            prog_we;
    logic [PC_W-1:0] prog_addr;
    logic [15:0]     prog_wdata;
    logic            branch_en;
    logic            take_branch;
    logic [15:0]     instruction;
    logic [PC_W-1:0] pc;
    logic            instr_valid;
    logic            halted;
    logic [7:0]      retired_cnt;

    modport slave (
        input  step, start, prog_we, prog_addr, prog_wdata, branch_en, take_branch,
        output instruction, pc, instr_valid, halted, retired_cnt
    );

    modport master (
        output step, start, prog_we, prog_addr, prog_wdata, branch_en, take_branch,
        input  instruction, pc, instr_valid, halted, retired_cnt
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch/sequencing unit: writable program memory, PC, and an
// IDLE/RUN/HALT sequencer that advances one instruction per step edge.
module instr_fetch #(
    parameter int          PROG_DEPTH = 16,
    parameter logic [3:0]  HALT_OP    = 4'hF
) (
    input  logic         clk,
    input  logic         rst_general_n,
    instr_fetch_if.slave bus
);
    localparam int PC_W = $clog2(PROG_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    typedef struct packed {
        logic [15:0]     instruction;
        logic [PC_W-1:0] pc;
        logic            valid;
        logic            halted;
        logic [7:0]      retired;
    } fetch_t;

    state_t          state, state_nxt;
    fetch_t          f;
    logic            step_q;
    logic            step_edge;
    logic            do_start, do_adv, do_halt, mem_we;
    logic            taken;
    logic [PC_W-1:0] offset;
    logic [PC_W-1:0] next_pc;
    logic [15:0]     mem [PROG_DEPTH];

    assign step_edge = bus.step & ~step_q;
    assign taken     = bus.branch_en & bus.take_branch;

    // The sum wraps mod PROG_DEPTH, so only the low PC_W bits of the
    // sign-extended offset matter (PC_W <= 8 for depths up to 256).
    assign offset  = taken ? f.instruction[PC_W-1:0] : '0;
    assign next_pc = f.pc + PC_W'(1) + offset;

    always_ff @(posedge clk or negedge rst_general_n) begin
        if (!rst_general_n) state <= S_IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_start  = 1'b0;
        do_adv    = 1'b0;
        do_halt   = 1'b0;
        mem_we    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    do_start  = 1'b1;
                    state_nxt = S_RUN;
                end else if (bus.prog_we) begin
                    mem_we = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.start) begin
                    do_start = 1'b1;
                end else if (step_edge) begin
                    if (f.instruction[15:12] == HALT_OP) begin
                        do_halt   = 1'b1;
                        state_nxt = S_HALT;
                    end else begin
                        do_adv = 1'b1;
                    end
                end
            end
            S_HALT: begin
                if (bus.start) begin
                    do_start  = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Program memory is deliberately outside the reset domain so it survives reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[bus.prog_addr] <= bus.prog_wdata;
    end

    always_ff @(posedge clk or negedge rst_general_n) begin
        if (!rst_general_n) begin
            f      <= '0;
            step_q <= 1'b0;
        end else begin
            step_q <= bus.step;
            if (do_start) begin
                f.pc          <= '0;
                f.instruction <= mem[0];
                f.valid       <= 1'b1;
                f.halted      <= 1'b0;
                f.retired     <= 8'd0;
            end else if (do_halt) begin
                f.halted <= 1'b1;
            end else if (do_adv) begin
                f.pc          <= next_pc;
                f.instruction <= mem[next_pc];
                f.retired     <= f.retired + 8'd1;
            end
        end
    end

    assign bus.instruction = f.instruction;
    assign bus.pc          = f.pc;
    assign bus.instr_valid = f.valid;
    assign bus.halted      = f.halted;
    assign bus.retired_cnt = f.retired;
endmodule
